// File: rtl/vga_console_writer.sv
// vga_console_writer: text-console front end for the VGA character display.
// Accepts one byte at a time over valid/ready, keeps a cursor, and drives the
// character-memory write port for characters, backspace, line/row wrap with
// clear-on-entry, and form-feed full-screen clear.
module vga_console_writer #(
  parameter int COLS           = 80,
  parameter int ROWS           = 30,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        char_we,
  output logic [11:0] char_addr,
  output logic [31:0] char_value,
  output logic [4:0]  cursor_row,
  output logic [6:0]  cursor_col,
  output logic        busy
);

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  localparam logic [7:0] NCOLS    = 8'(COLS);

  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_FF  = 8'h0C;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [6:0] BLANK  = 7'h20;

  typedef enum logic [1:0] {IDLE, PROC, CLRROW, CLRALL} state_t;

  state_t      state_reg;
  logic [4:0]  row_reg;       // committed cursor, visible while idle
  logic [6:0]  col_reg;
  logic [4:0]  pend_row_reg;  // cursor to commit when returning to IDLE
  logic [6:0]  pend_col_reg;
  logic        adv_reg;       // printable at last column: row clear follows
  logic [4:0]  clr_row_reg;   // clear walker position
  logic [7:0]  clr_col_reg;   // next column to clear; reaches COLS when a row is done
  logic        we_reg;
  logic [11:0] addr_reg;
  logic [6:0]  ascii_reg;

  logic [4:0]  adv_row;
  logic        is_print;

  // Row that a line advance lands on, and printable-range decode of the input.
  assign adv_row  = (row_reg == LAST_ROW) ? 5'd0 : row_reg + 5'd1;
  assign is_print = (in_data >= 8'h20) && (in_data <= 8'h7E);

  assign in_ready   = (state_reg == IDLE);
  assign busy       = (state_reg != IDLE);
  assign char_we    = we_reg;
  assign char_addr  = addr_reg;
  assign char_value = {25'h0, ascii_reg};
  assign cursor_row = row_reg;
  assign cursor_col = col_reg;

  // Control FSM; the write port is registered so each cycle shows the write for that cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= (CLEAR_ON_RESET != 0) ? CLRALL : IDLE;
      row_reg      <= 5'd0;
      col_reg      <= 7'd0;
      pend_row_reg <= 5'd0;
      pend_col_reg <= 7'd0;
      adv_reg      <= 1'b0;
      clr_row_reg  <= 5'd0;
      clr_col_reg  <= 8'd0;
      we_reg       <= 1'b0;
      addr_reg     <= 12'd0;
      ascii_reg    <= 7'd0;
    end else begin
      we_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            // Decode at acceptance so the resulting write appears in the very next cycle.
            state_reg    <= PROC;
            adv_reg      <= 1'b0;
            pend_row_reg <= row_reg;
            pend_col_reg <= col_reg;
            if (is_print) begin
              we_reg    <= 1'b1;
              addr_reg  <= {row_reg, col_reg};
              ascii_reg <= in_data[6:0];
              if (col_reg != LAST_COL) begin
                pend_col_reg <= col_reg + 7'd1;
              end else begin
                pend_col_reg <= 7'd0;
                pend_row_reg <= adv_row;
                adv_reg      <= 1'b1;
              end
            end else if (in_data == CH_LF) begin
              // Line feed skips PROC and starts clearing the new row immediately.
              state_reg    <= CLRROW;
              pend_col_reg <= 7'd0;
              pend_row_reg <= adv_row;
              we_reg       <= 1'b1;
              addr_reg     <= {adv_row, 7'd0};
              ascii_reg    <= BLANK;
              clr_col_reg  <= 8'd1;
            end else if (in_data == CH_CR) begin
              pend_col_reg <= 7'd0;
            end else if (in_data == CH_BS) begin
              if (col_reg != 7'd0) begin
                we_reg       <= 1'b1;
                addr_reg     <= {row_reg, col_reg - 7'd1};
                ascii_reg    <= BLANK;
                pend_col_reg <= col_reg - 7'd1;
              end
            end else if (in_data == CH_FF) begin
              state_reg   <= CLRALL;
              we_reg      <= 1'b1;
              addr_reg    <= 12'd0;
              ascii_reg   <= BLANK;
              clr_row_reg <= 5'd0;
              clr_col_reg <= 8'd1;
            end
          end
        end

        PROC: begin
          if (adv_reg) begin
            state_reg   <= CLRROW;
            we_reg      <= 1'b1;
            addr_reg    <= {pend_row_reg, 7'd0};
            ascii_reg   <= BLANK;
            clr_col_reg <= 8'd1;
          end else begin
            state_reg <= IDLE;
            row_reg   <= pend_row_reg;
            col_reg   <= pend_col_reg;
          end
        end

        CLRROW: begin
          if (clr_col_reg < NCOLS) begin
            we_reg      <= 1'b1;
            addr_reg    <= {pend_row_reg, clr_col_reg[6:0]};
            ascii_reg   <= BLANK;
            clr_col_reg <= clr_col_reg + 8'd1;
          end else begin
            state_reg <= IDLE;
            row_reg   <= pend_row_reg;
            col_reg   <= pend_col_reg;
          end
        end

        CLRALL: begin
          // Row-major walk; columns beyond COLS-1 are never touched.
          if (clr_col_reg < NCOLS) begin
            we_reg      <= 1'b1;
            addr_reg    <= {clr_row_reg, clr_col_reg[6:0]};
            ascii_reg   <= BLANK;
            clr_col_reg <= clr_col_reg + 8'd1;
          end else if (clr_row_reg != LAST_ROW) begin
            we_reg      <= 1'b1;
            addr_reg    <= {clr_row_reg + 5'd1, 7'd0};
            ascii_reg   <= BLANK;
            clr_row_reg <= clr_row_reg + 5'd1;
            clr_col_reg <= 8'd1;
          end else begin
            state_reg <= IDLE;
            row_reg   <= 5'd0;
            col_reg   <= 7'd0;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
